cut_driver: RTL and testbench

Stepper-motor driver for the cutter, directly downstream of the cut controller: it consumes the registered enable and direction outputs and turns them into a coil phase sequence for a 4-wire unipolar stepper. It paces steps with a clock divider and counts steps per stroke. It reports stroke completion and holds the rotor energized until the controller releases it.

---
 rtl/cut_driver.sv | 124 ++++++++++++
 tb/tb_cut_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cut_driver.sv
// Stepper-motor coil sequencer for the cutter: paces steps, counts a stroke, holds torque.
// Define CUT_DRIVER_HALFSTEP_EN for the 8-entry half-step sequence; otherwise full-step.
module cut_driver #(
    parameter int STEP_DIV     = 250000,
    parameter int STROKE_STEPS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        direction_i,
    output logic [3:0]  coil_o,
    output logic        busy_o,
    output logic        stroke_done_o,
    output logic [15:0] step_cnt_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int              DIV_W       = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(STEP_DIV - 1);
    localparam logic [15:0]     STROKE_LAST = 16'(STROKE_STEPS);

    logic [1:0]       state;
    logic [DIV_W-1:0] div;
    logic [2:0]       phase;
    logic             dir_q;
    logic [2:0]       phase_next;
    logic [15:0]      cnt_next;

    function automatic logic [3:0] pattern(input logic [2:0] p);
        logic [3:0] pat;
`ifdef CUT_DRIVER_HALFSTEP_EN
        case (p)
            3'd0:    pat = 4'b0001;
            3'd1:    pat = 4'b0011;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b1100;
            3'd6:    pat = 4'b1000;
            default: pat = 4'b1001;
        endcase
`else
        // phase[2] is always 0 in this build, so the upper half simply mirrors the lower.
        case (p)
            3'd0, 3'd4: pat = 4'b0011;
            3'd1, 3'd5: pat = 4'b0110;
            3'd2, 3'd6: pat = 4'b1100;
            default:    pat = 4'b1001;
        endcase
`endif
        return pat;
    endfunction

    always_comb begin
`ifdef CUT_DRIVER_HALFSTEP_EN
        phase_next = dir_q ? (phase - 3'd1) : (phase + 3'd1);
`else
        phase_next = {1'b0, (dir_q ? (phase[1:0] - 2'd1) : (phase[1:0] + 2'd1))};
`endif
        cnt_next = step_cnt_o + 16'd1;
    end

    // Disable beats a direction change, which beats a pending step; phase survives everything but rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            div           <= '0;
            phase         <= 3'd0;
            dir_q         <= 1'b0;
            coil_o        <= 4'b0000;
            busy_o        <= 1'b0;
            stroke_done_o <= 1'b0;
            step_cnt_o    <= 16'd0;
        end else begin
            stroke_done_o <= 1'b0;
            if (state == ST_IDLE) begin
                div        <= '0;
                step_cnt_o <= 16'd0;
                if (en_i) begin
                    state  <= ST_RUN;
                    dir_q  <= direction_i;
                    coil_o <= pattern(phase);
                    busy_o <= 1'b1;
                end else begin
                    coil_o <= 4'b0000;
                    busy_o <= 1'b0;
                end
            end else if (!en_i) begin
                state      <= ST_IDLE;
                div        <= '0;
                step_cnt_o <= 16'd0;
                coil_o     <= 4'b0000;
                busy_o     <= 1'b0;
            end else if (direction_i != dir_q) begin
                state      <= ST_RUN;
                dir_q      <= direction_i;
                div        <= '0;
                step_cnt_o <= 16'd0;
                busy_o     <= 1'b1;
            end else if (state == ST_RUN) begin
                if (div == DIV_LAST) begin
                    div        <= '0;
                    phase      <= phase_next;
                    coil_o     <= pattern(phase_next);
                    step_cnt_o <= cnt_next;
                    if (cnt_next == STROKE_LAST) begin
                        state         <= ST_HOLD;
                        busy_o        <= 1'b0;
                        stroke_done_o <= 1'b1;
                    end
                end else begin
                    div <= div + DIV_W'(1);
                end
            end else begin
                state  <= ST_HOLD;
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cut_driver.sv
// Bench for cut_driver: directed literal checks plus randomized traffic against a stroke-level model.
// Honors CUT_DRIVER_HALFSTEP_EN the same way the design does.
module tb_cut_driver;

    localparam int STEP_DIV     = 4;
    localparam int STROKE_STEPS = 3;
`ifdef CUT_DRIVER_HALFSTEP_EN
    localparam int SEQ_LEN = 8;
`else
    localparam int SEQ_LEN = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic        direction_i;
    logic [3:0]  coil_o;
    logic        busy_o;
    logic        stroke_done_o;
    logic [15:0] step_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] seq [SEQ_LEN];

    // Model state: mode 0 = off, 1 = stepping, 2 = holding; ticks = cycles since last step or start.
    int         m_mode = 0;
    int         m_pos  = 0;
    int         m_cnt  = 0;
    int         m_ticks = 0;
    logic       m_dir  = 1'b0;
    logic       m_pulse = 1'b0;
    logic       check_en = 1'b0;

    cut_driver #(
        .STEP_DIV     (STEP_DIV),
        .STROKE_STEPS (STROKE_STEPS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_i),
        .direction_i   (direction_i),
        .coil_o        (coil_o),
        .busy_o        (busy_o),
        .stroke_done_o (stroke_done_o),
        .step_cnt_o    (step_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
`ifdef CUT_DRIVER_HALFSTEP_EN
        seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
`else
        seq = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
`endif
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic d, input int cycles);
        rst         = r;
        en_i        = e;
        direction_i = d;
        repeat (cycles) @(negedge clk);
    endtask

    // Advance the model by one clock using the inputs as seen at this edge.
    always @(posedge clk) begin
        m_pulse = 1'b0;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_cnt = 0; m_ticks = 0; m_dir = 1'b0;
            check_en = 1'b1;
        end else if (m_mode == 0) begin
            m_cnt = 0; m_ticks = 0;
            if (en_i) begin
                m_mode = 1; m_dir = direction_i;
            end
        end else if (!en_i) begin
            m_mode = 0; m_cnt = 0; m_ticks = 0;
        end else if (direction_i != m_dir) begin
            m_mode = 1; m_dir = direction_i; m_cnt = 0; m_ticks = 0;
        end else if (m_mode == 1) begin
            m_ticks++;
            if (m_ticks == STEP_DIV) begin
                m_ticks = 0;
                m_pos   = m_dir ? (m_pos + SEQ_LEN - 1) % SEQ_LEN : (m_pos + 1) % SEQ_LEN;
                m_cnt++;
                if (m_cnt == STROKE_STEPS) begin
                    m_mode  = 2;
                    m_pulse = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_coil", {12'd0, coil_o}, {12'd0, (m_mode == 0) ? 4'b0000 : seq[m_pos]});
            checkOutput("model_busy", {15'd0, busy_o}, {15'd0, (m_mode == 1)});
            checkOutput("model_done", {15'd0, stroke_done_o}, {15'd0, m_pulse});
            checkOutput("model_cnt", step_cnt_o, 16'(m_cnt));
        end
    end

    initial begin
        logic r, e, d;
        rst = 1'b1; en_i = 1'b1; direction_i = 1'b0;
        @(negedge clk);

        applyStimulus(1, 1, 0, 1);
        checkOutput("rst1_coil", {12'd0, coil_o}, 16'h0000);
        checkOutput("rst1_busy", {15'd0, busy_o}, 16'h0000);
        applyStimulus(1, 1, 0, 1);
        checkOutput("rst2_coil", {12'd0, coil_o}, 16'h0000);
        checkOutput("rst2_cnt", step_cnt_o, 16'h0000);
        checkOutput("rst2_done", {15'd0, stroke_done_o}, 16'h0000);

`ifdef CUT_DRIVER_HALFSTEP_EN
        applyStimulus(0, 1, 0, 1);
        checkOutput("hs_entry", {12'd0, coil_o}, 16'b0001);
        applyStimulus(0, 1, 0, 4);
        checkOutput("hs_step1", {12'd0, coil_o}, 16'b0011);
        applyStimulus(0, 1, 0, 4);
        checkOutput("hs_step2", {12'd0, coil_o}, 16'b0010);
        applyStimulus(0, 1, 0, 4);
        checkOutput("hs_step3", {12'd0, coil_o}, 16'b0110);
        checkOutput("hs_done", {15'd0, stroke_done_o}, 16'h0001);
`else
        applyStimulus(0, 1, 0, 1);
        checkOutput("cw_entry", {12'd0, coil_o}, 16'b0011);
        checkOutput("cw_busy", {15'd0, busy_o}, 16'h0001);
        applyStimulus(0, 1, 0, 4);
        checkOutput("cw_step1", {12'd0, coil_o}, 16'b0110);
        applyStimulus(0, 1, 0, 4);
        checkOutput("cw_step2", {12'd0, coil_o}, 16'b1100);
        checkOutput("cw_nodone", {15'd0, stroke_done_o}, 16'h0000);
        applyStimulus(0, 1, 0, 4);
        checkOutput("cw_step3", {12'd0, coil_o}, 16'b1001);
        checkOutput("cw_done", {15'd0, stroke_done_o}, 16'h0001);
        checkOutput("cw_cnt", step_cnt_o, 16'd3);
        applyStimulus(0, 1, 0, 1);
        checkOutput("hold_done", {15'd0, stroke_done_o}, 16'h0000);
        checkOutput("hold_busy", {15'd0, busy_o}, 16'h0000);
        checkOutput("hold_coil", {12'd0, coil_o}, 16'b1001);

        applyStimulus(0, 1, 1, 1);
        checkOutput("ccw_restart", {12'd0, coil_o}, 16'b1001);
        checkOutput("ccw_cnt0", step_cnt_o, 16'd0);
        applyStimulus(0, 1, 1, 4);
        checkOutput("ccw_step1", {12'd0, coil_o}, 16'b1100);
        applyStimulus(0, 1, 1, 4);
        checkOutput("ccw_step2", {12'd0, coil_o}, 16'b0110);
        applyStimulus(0, 1, 1, 4);
        checkOutput("ccw_step3", {12'd0, coil_o}, 16'b0011);
        checkOutput("ccw_done", {15'd0, stroke_done_o}, 16'h0001);

        applyStimulus(0, 0, 1, 1);
        checkOutput("off_coil", {12'd0, coil_o}, 16'h0000);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 1, 0, 8);
        checkOutput("abort_pre", {12'd0, coil_o}, 16'b1100);
        checkOutput("abort_precnt", step_cnt_o, 16'd2);
        applyStimulus(0, 0, 0, 1);
        checkOutput("abort_coil", {12'd0, coil_o}, 16'h0000);
        checkOutput("abort_cnt", step_cnt_o, 16'd0);
        applyStimulus(0, 1, 0, 1);
        checkOutput("resume_coil", {12'd0, coil_o}, 16'b1100);

        applyStimulus(0, 1, 0, 8);
        checkOutput("coll_pre", {12'd0, coil_o}, 16'b0011);
        applyStimulus(0, 1, 0, 3);
        applyStimulus(0, 0, 0, 1);
        checkOutput("coll_coil", {12'd0, coil_o}, 16'h0000);
        checkOutput("coll_done", {15'd0, stroke_done_o}, 16'h0000);
        checkOutput("coll_cnt", step_cnt_o, 16'd0);
`endif

        d = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 59) == 0) d = ~d;
            applyStimulus(r, e, d, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
